pc_gen_unit: RTL

- Parametrised program-counter generator, successor to the single-cycle PC register. Owns the architectural PC and issues it to the IFU over a valid/ready handshake.
- Waits for the EXU to resolve the fetched instruction, then computes the next PC: sequential, conditional branch, jump, trap entry or halt.
- Sits between the IFU and the EXU/CSR file in the multi-cycle NPC core.
- Also provides a retired-instruction counter.

---
 rtl/pc_gen_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: architectural PC owner issuing fetch PCs over valid/ready and stepping on EXU resolution.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_CHK_EN.
module pc_gen_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h8000_0000,
    parameter int                CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_pc_valid,
    input  logic             ifu_pc_ready,
    output logic [XLEN-1:0]  ifu_pc,
    input  logic             exu_valid,
    input  logic [1:0]       exu_kind,
    input  logic             exu_cmp,
    input  logic             exu_inv,
    input  logic [XLEN-1:0]  exu_target,
    input  logic             exu_halt,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vec,
    output logic             misalign,
    output logic [XLEN-1:0]  pc_cur,
    output logic             halted,
    output logic [CNT_W-1:0] retire_cnt
);
    typedef enum logic [1:0] {BOOT, ISSUE, WAIT, HALT} state_t;
    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d, seq, tgt, npc, tvec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mis_q, mis_d;
    always_comb begin
        seq     = pc_q + XLEN'(4);
        tgt     = {exu_target[XLEN-1:1], 1'b0};
        tvec    = {trap_vec[XLEN-1:2], 2'b00};
        npc     = (exu_kind == 2'b10 || (exu_kind == 2'b01 && (exu_cmp ^ exu_inv))) ? tgt : seq;
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        case (state_q)
            BOOT:  state_d = ISSUE;
            ISSUE: state_d = ifu_pc_ready ? WAIT : ISSUE;
            WAIT: begin
                if (trap_valid) begin
                    pc_d    = tvec;
                    state_d = ISSUE;
                end else if (exu_valid && exu_halt) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = HALT;
                end else if (exu_valid) begin
                    state_d = ISSUE;
`ifdef PC_MISALIGN_CHK_EN
                    // A target landing on bit 1 redirects to the trap vector without retiring.
                    if (npc[1]) begin
                        mis_d = 1'b1;
                        pc_d  = tvec;
                    end else begin
                        pc_d  = npc;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    pc_d  = npc;
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = HALT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end
    assign ifu_pc_valid = state_q == ISSUE;
    assign ifu_pc       = pc_q;
    assign pc_cur       = pc_q;
    assign halted       = state_q == HALT;
    assign retire_cnt   = cnt_q;
`ifdef PC_MISALIGN_CHK_EN
    assign misalign     = mis_q;
`else
    assign misalign     = 1'b0;
`endif
endmodule
